// File: rtl/cnn_pkg.sv
// cnn_pkg: state encoding, layer descriptor type, field widths and the default
// layer table shared by the layer sequencer and its output-width calculator.
package cnn_pkg;

    localparam int CNN_IW_W = 5;
    localparam int CNN_KW_W = 2;
    localparam int CNN_ST_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    typedef struct packed {
        logic [CNN_IW_W-1:0] iw;
        logic [CNN_KW_W-1:0] kw;
        logic [CNN_ST_W-1:0] st;
    } layer_cfg_t;

    // Entries past the defined network fall back to a pass-through 5/1/1 layer.
    function automatic layer_cfg_t default_cfg(input int idx);
        case (idx)
            0:       return '{iw: CNN_IW_W'(28), kw: CNN_KW_W'(3), st: CNN_ST_W'(1)};
            1:       return '{iw: CNN_IW_W'(26), kw: CNN_KW_W'(2), st: CNN_ST_W'(2)};
            2:       return '{iw: CNN_IW_W'(13), kw: CNN_KW_W'(3), st: CNN_ST_W'(1)};
            3:       return '{iw: CNN_IW_W'(11), kw: CNN_KW_W'(2), st: CNN_ST_W'(2)};
            default: return '{iw: CNN_IW_W'(5),  kw: CNN_KW_W'(1), st: CNN_ST_W'(1)};
        endcase
    endfunction

endpackage

// File: rtl/out_width_calc.sv
// out_width_calc: combinational convolution output width (iw - kw) / st + 1
// with floor division, plus detection of geometries that cannot be issued.
module out_width_calc #(
    parameter int IW_W = 5,
    parameter int KW_W = 2,
    parameter int ST_W = 2
) (
    input  logic [IW_W-1:0] i_iw,
    input  logic [KW_W-1:0] i_kw,
    input  logic [ST_W-1:0] i_st,
    output logic [IW_W-1:0] o_ow,
    output logic            o_geom_err
);

    logic [IW_W-1:0] w_kw;
    logic [IW_W-1:0] w_diff;

    assign w_kw       = IW_W'(i_kw);
    assign w_diff     = i_iw - w_kw;
    assign o_geom_err = (w_kw > i_iw) || (i_st == '0) || (i_kw == '0);
    // Bad geometry forces zero so a divide-by-zero never reaches the output.
    assign o_ow       = o_geom_err ? '0 : (w_diff / IW_W'(i_st)) + IW_W'(1);

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: walks the CNN layer table, issuing each layer's geometry to the datapath.
// Optional LAYER_SEQ_CFG_WR_EN turns the table into host-writable registers.
module layer_sequencer
    import cnn_pkg::*;
#(
    parameter int NUM_LAYERS = 6,
    parameter int IW_W       = CNN_IW_W,
    parameter int KW_W       = CNN_KW_W,
    parameter int ST_W       = CNN_ST_W,
    localparam int IDX_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  layer_done,
`ifdef LAYER_SEQ_CFG_WR_EN
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_addr,
    input  logic [IW_W-1:0]       cfg_iw,
    input  logic [KW_W-1:0]       cfg_kw,
    input  logic [ST_W-1:0]       cfg_st,
`endif
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic                  layer_start,
    output logic [NUM_LAYERS-1:0] layer_active,
    output logic [IDX_W-1:0]      layer_idx,
    output logic [IW_W-1:0]       input_width,
    output logic [KW_W-1:0]       kernel_width,
    output logic [ST_W-1:0]       stride,
    output logic [IW_W-1:0]       output_width
);

    state_t                r_state;
    logic                  r_ready;
    logic                  r_done;
    logic                  r_err;
    logic                  r_lstart;
    logic [NUM_LAYERS-1:0] r_active;
    logic [IDX_W-1:0]      r_idx;
    logic [IW_W-1:0]       r_iw;
    logic [KW_W-1:0]       r_kw;
    logic [ST_W-1:0]       r_st;
    logic [IW_W-1:0]       r_ow;

    logic [IDX_W-1:0]      w_next_idx;
    logic                  w_last;
    logic                  w_issue;
    layer_cfg_t            w_cfg;
    logic [IW_W-1:0]       w_iw;
    logic [KW_W-1:0]       w_kw;
    logic [ST_W-1:0]       w_st;
    logic [IW_W-1:0]       w_ow;
    logic                  w_geom_err;

    assign w_last     = (r_idx == IDX_W'(NUM_LAYERS - 1));
    assign w_next_idx = (r_state == S_IDLE) ? '0 : r_idx + IDX_W'(1);
    assign w_issue    = ((r_state == S_IDLE) && start) ||
                        ((r_state == S_RUN) && layer_done && !w_last);

`ifdef LAYER_SEQ_CFG_WR_EN
    // Table is sized to the full index space so lookahead past the last layer stays in range.
    layer_cfg_t r_table [1 << IDX_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < (1 << IDX_W); i++) r_table[i] <= default_cfg(i);
        end else if (cfg_we && r_ready && (int'(cfg_addr) < NUM_LAYERS)) begin
            r_table[cfg_addr] <= '{iw: CNN_IW_W'(cfg_iw), kw: CNN_KW_W'(cfg_kw), st: CNN_ST_W'(cfg_st)};
        end
    end

    assign w_cfg = r_table[w_next_idx];
`else
    assign w_cfg = default_cfg(int'(w_next_idx));
`endif

    assign w_iw = IW_W'(w_cfg.iw);
    assign w_kw = KW_W'(w_cfg.kw);
    assign w_st = ST_W'(w_cfg.st);

    out_width_calc #(
        .IW_W (IW_W),
        .KW_W (KW_W),
        .ST_W (ST_W)
    ) u_owc (
        .i_iw       (w_iw),
        .i_kw       (w_kw),
        .i_st       (w_st),
        .o_ow       (w_ow),
        .o_geom_err (w_geom_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_lstart <= 1'b0;
            r_active <= '0;
            r_idx    <= '0;
            r_iw     <= '0;
            r_kw     <= '0;
            r_st     <= '0;
            r_ow     <= '0;
        end else begin
            r_lstart <= 1'b0;
            r_done   <= 1'b0;
            // Abort shares the return-to-idle path but never pulses done or touches cfg_err.
            if (abort || (r_state == S_DONE) || (r_state == S_ERR)) begin
                r_state  <= S_IDLE;
                r_ready  <= 1'b1;
                r_active <= '0;
                r_idx    <= '0;
                r_iw     <= '0;
                r_kw     <= '0;
                r_st     <= '0;
                r_ow     <= '0;
            end else if (w_issue) begin
                r_state  <= w_geom_err ? S_ERR : S_ISSUE;
                r_ready  <= 1'b0;
                r_lstart <= !w_geom_err;
                r_done   <= w_geom_err;
                r_err    <= w_geom_err;
                r_idx    <= w_next_idx;
                r_active <= NUM_LAYERS'(1) << w_next_idx;
                r_iw     <= w_iw;
                r_kw     <= w_kw;
                r_st     <= w_st;
                r_ow     <= w_ow;
            end else if (r_state == S_ISSUE) begin
                r_state <= S_RUN;
            end else if ((r_state == S_RUN) && layer_done) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
            end
        end
    end

    assign ready        = r_ready;
    assign busy         = ~r_ready;
    assign done         = r_done;
    assign cfg_err      = r_err;
    assign layer_start  = r_lstart;
    assign layer_active = r_active;
    assign layer_idx    = r_idx;
    assign input_width  = r_iw;
    assign kernel_width = r_kw;
    assign stride       = r_st;
    assign output_width = r_ow;

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed self-checking bench for layer_sequencer;
// the table-write scenarios build only with LAYER_SEQ_CFG_WR_EN defined.
module tb_layer_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       layer_done = 1'b0;
    logic       ready, busy, done, cfg_err, layer_start;
    logic [5:0] layer_active;
    logic [2:0] layer_idx;
    logic [4:0] input_width, output_width;
    logic [1:0] kernel_width, stride;
`ifdef LAYER_SEQ_CFG_WR_EN
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [4:0] cfg_iw = '0;
    logic [1:0] cfg_kw = '0;
    logic [1:0] cfg_st = '0;
`endif

    int checks = 0;
    int errors = 0;
    int exp_ow [6] = '{26, 13, 11, 5, 5, 5};
    int exp_iw [6] = '{28, 26, 13, 11, 5, 5};

    always #5 clk = ~clk;

    layer_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .layer_done   (layer_done),
`ifdef LAYER_SEQ_CFG_WR_EN
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_iw       (cfg_iw),
        .cfg_kw       (cfg_kw),
        .cfg_st       (cfg_st),
`endif
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err),
        .layer_start  (layer_start),
        .layer_active (layer_active),
        .layer_idx    (layer_idx),
        .input_width  (input_width),
        .kernel_width (kernel_width),
        .stride       (stride),
        .output_width (output_width)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({ready, busy, done, cfg_err, layer_start} !== 5'b10000 || layer_active !== 6'h00 ||
            layer_idx !== 3'd0 || input_width !== 5'd0 || output_width !== 5'd0 ||
            kernel_width !== 2'd0 || stride !== 2'd0) begin
            $display("FAIL reset_state: rdy/busy/done/err/ls=%b act=%h idx=%0d iw=%0d ow=%0d, want 10000 00 0 0 0",
                     {ready, busy, done, cfg_err, layer_start}, layer_active, layer_idx, input_width, output_width);
            errors++;
        end
        reset = 1'b1;
        step();
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL reset_release: ready=%b busy=%b, want 1 0", ready, busy);
            errors++;
        end
    endtask

    task automatic test_normal_run();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (layer_start !== 1'b1 || layer_active !== 6'(1 << k) || layer_idx !== 3'(k) ||
                input_width !== 5'(exp_iw[k]) || output_width !== 5'(exp_ow[k])) begin
                $display("FAIL normal_issue L%0d: ls=%b act=%h idx=%0d iw=%0d ow=%0d, want 1 %h %0d %0d %0d",
                         k, layer_start, layer_active, layer_idx, input_width, output_width,
                         6'(1 << k), k, exp_iw[k], exp_ow[k]);
                errors++;
            end
            step();
            checks++;
            if (layer_start !== 1'b0 || busy !== 1'b1 || output_width !== 5'(exp_ow[k]) ||
                input_width !== 5'(exp_iw[k])) begin
                $display("FAIL normal_hold L%0d: ls=%b busy=%b iw=%0d ow=%0d, want 0 1 %0d %0d",
                         k, layer_start, busy, input_width, output_width, exp_iw[k], exp_ow[k]);
                errors++;
            end
            step();
            step();
            layer_done = 1'b1;
            step();
            layer_done = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || ready !== 1'b0 || layer_start !== 1'b0) begin
            $display("FAIL normal_done: done=%b ready=%b ls=%b, want 1 0 0", done, ready, layer_start);
            errors++;
        end
        step();
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || layer_active !== 6'h00 ||
            output_width !== 5'd0 || layer_idx !== 3'd0 || cfg_err !== 1'b0) begin
            $display("FAIL normal_idle: ready=%b done=%b busy=%b act=%h ow=%0d idx=%0d err=%b, want 1 0 0 00 0 0 0",
                     ready, done, busy, layer_active, output_width, layer_idx, cfg_err);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (layer_start !== 1'b1 || layer_active !== 6'(1 << k) || output_width !== 5'(exp_ow[k])) begin
                $display("FAIL b2b_issue L%0d cycle %0d: ls=%b act=%h ow=%0d, want 1 %h %0d",
                         k, cyc, layer_start, layer_active, output_width, 6'(1 << k), exp_ow[k]);
                errors++;
            end
            step();
            cyc++;
            layer_done = 1'b1;
            step();
            cyc++;
            layer_done = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || layer_start !== 1'b0) begin
            $display("FAIL b2b_done cycle %0d: done=%b ls=%b, want 1 0", cyc, done, layer_start);
            errors++;
        end
        step();
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            $display("FAIL b2b_ready: ready=%b done=%b, want 1 0", ready, done);
            errors++;
        end
    endtask

    task automatic test_ignored();
        layer_done = 1'b1;
        step();
        layer_done = 1'b0;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || layer_start !== 1'b0 || layer_active !== 6'h00) begin
            $display("FAIL ign_idle_done: ready=%b busy=%b ls=%b act=%h, want 1 0 0 00",
                     ready, busy, layer_start, layer_active);
            errors++;
        end
        start = 1'b1;
        step();
        layer_done = 1'b1;
        step();
        layer_done = 1'b0;
        checks++;
        if (layer_start !== 1'b0 || layer_active !== 6'h01 || layer_idx !== 3'd0 || busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL ign_issue_done: ls=%b act=%h idx=%0d busy=%b done=%b, want 0 01 0 1 0",
                     layer_start, layer_active, layer_idx, busy, done);
            errors++;
        end
        step();
        start = 1'b0;
        checks++;
        if (layer_start !== 1'b0 || layer_idx !== 3'd0 || ready !== 1'b0 || output_width !== 5'd26) begin
            $display("FAIL ign_start_busy: ls=%b idx=%0d ready=%b ow=%0d, want 0 0 0 26",
                     layer_start, layer_idx, ready, output_width);
            errors++;
        end
        layer_done = 1'b1;
        step();
        layer_done = 1'b0;
        checks++;
        if (layer_start !== 1'b1 || layer_idx !== 3'd1 || output_width !== 5'd13) begin
            $display("FAIL ign_resume: ls=%b idx=%0d ow=%0d, want 1 1 13", layer_start, layer_idx, output_width);
            errors++;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_abort();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            layer_done = 1'b1;
            step();
            layer_done = 1'b0;
        end
        checks++;
        if (layer_start !== 1'b1 || layer_active !== 6'h04 || output_width !== 5'd11) begin
            $display("FAIL abort_reach_l2: ls=%b act=%h ow=%0d, want 1 04 11", layer_start, layer_active, output_width);
            errors++;
        end
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || layer_active !== 6'h00 || done !== 1'b0 ||
            layer_idx !== 3'd0 || output_width !== 5'd0) begin
            $display("FAIL abort_idle: ready=%b busy=%b act=%h done=%b idx=%0d ow=%0d, want 1 0 00 0 0 0",
                     ready, busy, layer_active, done, layer_idx, output_width);
            errors++;
        end
        step();
        checks++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            $display("FAIL abort_no_done: done=%b ready=%b, want 0 1", done, ready);
            errors++;
        end
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || layer_active !== 6'h00 || output_width !== 5'd0 ||
            layer_idx !== 3'd0 || done !== 1'b0) begin
            $display("FAIL async_reset: ready=%b busy=%b act=%h ow=%0d idx=%0d done=%b, want 1 0 00 0 0 0",
                     ready, busy, layer_active, output_width, layer_idx, done);
            errors++;
        end
        #2;
        reset = 1'b1;
        step();
        checks++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            $display("FAIL async_reset_after: done=%b ready=%b, want 0 1", done, ready);
            errors++;
        end
    endtask

`ifdef LAYER_SEQ_CFG_WR_EN
    task automatic cfg_write(input logic [2:0] a, input logic [4:0] iw, input logic [1:0] kw, input logic [1:0] st);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_iw   = iw;
        cfg_kw   = kw;
        cfg_st   = st;
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic test_cfg_error();
        cfg_write(3'd1, 5'd2, 2'd3, 2'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (layer_start !== 1'b1 || output_width !== 5'd26 || cfg_err !== 1'b0) begin
            $display("FAIL cfgerr_l0: ls=%b ow=%0d err=%b, want 1 26 0", layer_start, output_width, cfg_err);
            errors++;
        end
        step();
        layer_done = 1'b1;
        step();
        layer_done = 1'b0;
        checks++;
        if (done !== 1'b1 || cfg_err !== 1'b1 || layer_start !== 1'b0) begin
            $display("FAIL cfgerr_abort: done=%b err=%b ls=%b, want 1 1 0", done, cfg_err, layer_start);
            errors++;
        end
        step();
        checks++;
        if (ready !== 1'b1 || cfg_err !== 1'b1 || done !== 1'b0 || layer_start !== 1'b0) begin
            $display("FAIL cfgerr_sticky: ready=%b err=%b done=%b ls=%b, want 1 1 0 0", ready, cfg_err, done, layer_start);
            errors++;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (cfg_err !== 1'b0 || layer_start !== 1'b1) begin
            $display("FAIL cfgerr_clear: err=%b ls=%b, want 0 1", cfg_err, layer_start);
            errors++;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        cfg_write(3'd1, 5'd26, 2'd2, 2'd2);
    endtask

    task automatic test_cfg_stride3();
        cfg_write(3'd0, 5'd28, 2'd3, 2'd3);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (output_width !== 5'd9 || stride !== 2'd3 || layer_start !== 1'b1) begin
            $display("FAIL stride3_ow: ow=%0d st=%0d ls=%b, want 9 3 1", output_width, stride, layer_start);
            errors++;
        end
        cfg_write(3'd0, 5'd28, 2'd3, 2'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (output_width !== 5'd9 || stride !== 2'd3) begin
            $display("FAIL busy_write_dropped: ow=%0d st=%0d, want 9 3", output_width, stride);
            errors++;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        cfg_write(3'd0, 5'd28, 2'd3, 2'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (output_width !== 5'd26 || stride !== 2'd1) begin
            $display("FAIL idle_write_taken: ow=%0d st=%0d, want 26 1", output_width, stride);
            errors++;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_normal_run();
        test_back_to_back();
        test_ignored();
        test_abort();
        test_async_reset();
`ifdef LAYER_SEQ_CFG_WR_EN
        test_cfg_error();
        test_cfg_stride3();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Parametrised layer control FSM for the CNN accelerator: walks a configurable table of `NUM_LAYERS` convolution/pool layers and, for each layer, drives the layer geometry to the datapath. Geometry is input width, kernel width, stride and computed output width. It handshakes with the host via `start`/`ready`/`done` and with the datapath via `layer_start`/`layer_done`. Geometry errors are detected before issue and abort the run.

## Interface
- `NUM_LAYERS`, 6: number of layer table entries (≥1).
- `IW_W`, 5: input/output width field width.
- `KW_W`, 2: kernel width field width.
- `ST_W`, 2: stride field width.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  host request to run the full layer sequence.
- `abort`  in  1  synchronous abort; returns the block to IDLE.
- `layer_done`  in  1  datapath finished the current layer (single-cycle pulse).
- `ready`  out  1  idle and able to accept `start`.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse when the sequence ends (normal or error).
- `cfg_err`  out  1  sticky error flag; set on a bad geometry, cleared on the next accepted `start`.
- `layer_start`  out  1  one-cycle pulse; the geometry outputs are valid for a new layer.
- `layer_active`  out  NUM_LAYERS  one-hot index of the current layer; zero when idle.
- `layer_idx`  out  $clog2(NUM_LAYERS)  binary index of the current layer.
- `input_width`  out  IW_W  current layer input width.
- `kernel_width`  out  KW_W  current layer kernel width.
- `stride`  out  ST_W  current layer stride.
- `output_width`  out  IW_W  computed as (input_width − kernel_width)/stride + 1, floor division.

## Operation
- States:
  - IDLE: `ready`=1.
  - ISSUE: one cycle; `layer_start`=1.
  - RUN: waits for `layer_done`.
  - DONE: one cycle; `done`=1.
  - ERR: one cycle; `done`=1 and `cfg_err` set.
- IDLE + `start` → ISSUE for layer 0. `cfg_err` is cleared at the same edge.
- Entering ISSUE:
  - Load the table entry for `layer_idx` into the registered geometry outputs.
  - Set `layer_active` = 1<<`layer_idx`.
  - Geometry check: if kernel_width > input_width, stride = 0 or kernel_width = 0, go to ERR instead. In that case `layer_start` does not pulse.
- ISSUE → RUN unconditionally.
- RUN + `layer_done`:
  - If `layer_idx` = NUM_LAYERS−1 → DONE.
  - Otherwise increment `layer_idx` → ISSUE.
- DONE/ERR → IDLE. On entering IDLE, `layer_active`, `layer_idx` and the geometry outputs clear to 0.
- `layer_done` in any state other than RUN is ignored.
- `start` when not in IDLE is ignored.
- `abort` has priority over all transitions and `start`:
  - Any state → IDLE next edge.
  - No `done` pulse; `cfg_err` unchanged.
- `busy` = state ∈ {ISSUE, RUN, DONE, ERR}.
- Default table (iw/kw/st → ow):
  - L0: 28/3/1 → 26
  - L1: 26/2/2 → 13
  - L2: 13/3/1 → 11
  - L3: 11/2/2 → 5
  - L4: 5/1/1 → 5
  - L5: 5/1/1 → 5
  - Entries beyond 6 default to 5/1/1.
- Output-width arithmetic:
  - Unsigned, IW_W bits.
  - Floor division by stride, supporting strides 1..2^ST_W−1.
  - Computed combinationally from the table entry and registered with the other geometry outputs.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, `ready`=1.
  - All other outputs 0, including `cfg_err`.
  - Table restored to defaults.
- `start` sampled at edge 0 → `layer_start`, geometry and `layer_active` valid in cycle 1.
- `layer_done` at edge n (non-final layer) → next `layer_start` in cycle n+1. This is a one-cycle layer turnaround.
- Final `layer_done` at edge n → `done` in cycle n+1, `ready` in cycle n+2.
- Geometry outputs are stable from ISSUE through RUN.
- Reset mid-run returns immediately to IDLE without a `done` pulse.

## Configuration
- `LAYER_SEQ_CFG_WR_EN` defined:
  - Adds ports `cfg_we` (in, 1), `cfg_addr` (in, $clog2(NUM_LAYERS)), `cfg_iw` (in, IW_W), `cfg_kw` (in, KW_W), `cfg_st` (in, ST_W).
  - The table becomes registers, written when `cfg_we` is high and `ready` is high.
  - Writes while `busy` are dropped.
  - A `cfg_addr` ≥ NUM_LAYERS is dropped.
- Not defined: these ports are absent and the table is the constant defaults.

## Structure
- Package `cnn_pkg` holds:
  - The state enum.
  - A `layer_cfg_t` struct {iw, kw, st}.
  - The default-table function indexed by layer.
  - The field-width constants.
- Sub-module `out_width_calc`: combinational (iw, kw, st) → (ow, geom_err). It is instantiated once in the sequencer.

## Test plan
- Normal run:
  - Stimulus: reset, `start` pulse, then `layer_done` 3 cycles after each `layer_start`.
  - Required response: six `layer_start` pulses with ow sequence 26, 13, 11, 5, 5, 5 and `layer_active` sequence 0x01…0x20.
  - `done` one cycle after the 6th `layer_done`; `ready` the cycle after.
- Back-to-back: `layer_done` asserted in the first RUN cycle of every layer → a layer_start pulse on every other cycle; sequence completes `done` 13 cycles after start.
- Ignored inputs: spurious `layer_done` in IDLE and ISSUE, and `start` while `busy` → no state change.
- Abort/reset: `abort` in RUN of layer 2 → IDLE next cycle, `layer_active`=0, no `done`. Repeat with `reset` low asynchronously mid-cycle → outputs clear immediately.
- Config error (with `LAYER_SEQ_CFG_WR_EN`):
  - Write L1 = iw 2, kw 3, st 1, then start.
  - Required response: L0 runs, then `done` and `cfg_err` with no second `layer_start`.
  - Next `start` clears `cfg_err`.
- Stride-3 arithmetic and write gating (with `LAYER_SEQ_CFG_WR_EN`):
  - Write L0 = 28/3/3 → ow 9.
  - A write attempted while busy is ignored; verify the old value is used on the next run.
